// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline state encoding and EX bundle layout
package pipe_pkg;

    localparam logic [1:0] PIPE_ST_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_ST_ONE   = 2'd1;
    localparam logic [1:0] PIPE_ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        ST_EMPTY = PIPE_ST_EMPTY,
        ST_ONE   = PIPE_ST_ONE,
        ST_FULL  = PIPE_ST_FULL
    } pipe_state_e;

    // EX bundle, LSB first: length, rd_e, mem_addr, rd_addr, rd_data
    localparam int PIPE_EX_W          = 75;
    localparam int PIPE_EX_LENGTH_LSB = 0;
    localparam int PIPE_EX_RD_E_LSB   = 5;
    localparam int PIPE_EX_MEM_ADDR_LSB = 6;
    localparam int PIPE_EX_RD_ADDR_LSB  = 38;
    localparam int PIPE_EX_RD_DATA_LSB  = 43;

    function automatic logic [PIPE_EX_W-1:0] pipe_ex_pack(
        input logic [31:0] rd_data,
        input logic [4:0]  rd_addr,
        input logic [31:0] mem_addr,
        input logic        rd_e,
        input logic [4:0]  length
    );
        return {rd_data, rd_addr, mem_addr, rd_e, length};
    endfunction

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// rtl/pipe_skid_reg_sat_counter.sv - saturating event counter, cleared by rst only
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (rst) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - 2-entry skid pipeline register; PIPE_SKID_PERF_EN adds stall/bubble counters
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_EX_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              push, pop;

    assign push = in_valid & in_ready_q & rdy;
    assign pop  = (state_q != ST_EMPTY) & out_ready & rdy;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (rst || flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else if (rdy) begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        // Clearing main keeps out_data zero while empty.
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        in_ready_q <= in_ready_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;

`ifdef PIPE_SKID_PERF_EN
    logic stall_inc, bubble_inc;

    // Flush cycles leave the counters untouched.
    assign stall_inc  = rdy & ~flush & out_valid & ~out_ready;
    assign bubble_inc = rdy & ~flush & ~out_valid & out_ready;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and random checks of pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

    localparam int DW   = 75;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, rdy, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    logic [DW-1:0] mq[$];
    int            m_stall = 0;
    int            m_bubble = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit had, do_push;
        had = (mq.size() > 0);
        if (rst) begin
            mq.delete();
            m_stall  = 0;
            m_bubble = 0;
        end else if (flush) begin
            mq.delete();
        end else if (rdy) begin
`ifdef PIPE_SKID_PERF_EN
            if (had && !out_ready && m_stall < CMAX) m_stall++;
            if (!had && out_ready && m_bubble < CMAX) m_bubble++;
`endif
            do_push = in_valid && (mq.size() < 2);
            if (had && out_ready) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
        end
    endtask

    task automatic check_all();
        chk("out_valid", DW'(out_valid), DW'(mq.size() > 0));
        chk("out_data", out_data, (mq.size() > 0) ? mq[0] : '0);
        chk("in_ready", DW'(in_ready), DW'(mq.size() < 2));
        chk("occupancy", DW'(occupancy), DW'(mq.size()));
        chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
        chk("bubble_cnt", DW'(bubble_cnt), DW'(m_bubble));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [DW-1:0] vals[3];
        vals[0] = DW'('h11);
        vals[1] = DW'('h22);
        vals[2] = DW'('h33);

        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = DW'('h1234); out_ready = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_occ", DW'(occupancy), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst_valid", DW'(out_valid), '0);

        // Streaming at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = vals[i];
            tick();
            chk("stream_data", out_data, vals[i]);
            chk("stream_occ", DW'(occupancy), DW'(1));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = vals[0]; tick();
        in_data = vals[1]; tick();
        chk("bp_occ", DW'(occupancy), DW'(2));
        chk("bp_in_ready", DW'(in_ready), '0);
        in_data = vals[2]; tick();
        chk("bp_hold", out_data, vals[0]);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1", out_data, vals[1]);
        tick();
        chk("bp_drain2", out_data, vals[2]);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", DW'(occupancy), '0);

        // Global ready freeze while full
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = vals[0]; tick();
        in_data = vals[1]; tick();
        in_valid = 1'b0; out_ready = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_data", out_data, vals[0]);
            chk("frz_occ", DW'(occupancy), DW'(2));
        end
        rdy = 1'b1;
        tick();
        chk("frz_release", out_data, vals[1]);
        tick();

        // Flush while full with a concurrent push
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = DW'('hAA); tick();
        in_data = DW'('hBB); tick();
        in_data = DW'('hCC); flush = 1'b1;
        tick();
        chk("flush_occ", DW'(occupancy), '0);
        chk("flush_data", out_data, '0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_dropped", DW'(out_valid), '0);

        // Counter saturation, flush retention, reset clear
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = DW'('h5); tick();
        in_data = DW'('h6); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_SKID_PERF_EN
        chk("stall_sat", DW'(stall_cnt), DW'(3));
`else
        chk("stall_off", DW'(stall_cnt), '0);
`endif
        flush = 1'b1; tick(); flush = 1'b0;
`ifdef PIPE_SKID_PERF_EN
        chk("stall_flush", DW'(stall_cnt), DW'(3));
`else
        chk("stall_flush_off", DW'(stall_cnt), '0);
`endif
        rst = 1'b1; tick(); rst = 1'b0;
        chk("stall_rst", DW'(stall_cnt), '0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            rdy       = ($urandom_range(0, 99) < 85);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_data   = DW'({$urandom, $urandom, $urandom});
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
